axi_full_master_bridge: RTL and testbench
=========================================

// Module: axi_full_master_bridge
// PURPOSE
// - AXI4-Full master that turns a simple command/stream interface into single-ID INCR
//   bursts of 32-bit words. It is the initiator counterpart of the AXI4-Full to BRAM
//   slave in the trace framework.
// - Trace/control logic issues reads and writes to memory-mapped slaves (DDR, BRAM
//   controllers) through it.
// - One transaction is outstanding at a time; reads and writes are serialized.
// PARAMETERS
// C_M_AXI_ID_WIDTH      1    width of AWID/ARID/BID/RID; issued IDs are always 0
// C_M_AXI_USER_WIDTH    1    width of AWUSER/ARUSER/WUSER outputs; driven 0
// PORTS
// M_AXI_ACLK     in   1   clock; all logic on the rising edge
// M_AXI_ARESET   in   1   reset, asynchronous, active-high
// cmd_vld        in   1   command request
// cmd_rnw        in   1   1 = read, 0 = write
// cmd_addr       in   32  byte address; bits [1:0] ignored (forced 0)
// cmd_len        in   8   beats-1 (AXI LEN encoding, 0..255)
// cmd_ack        out  1   one-cycle pulse: command consumed
// wr_data        in   32  write beat data
// wr_strb        in   4   write beat byte strobes
// wr_vld         in   1   write beat available
// wr_ack         out  1   write beat consumed (=WVALID&WREADY)
// rd_data        out  32  read beat data (=RDATA)
// rd_vld         out  1   read beat valid
// rd_last        out  1   last beat of read burst (=RLAST)
// rd_rdy         in   1   downstream ready for read beat
// busy           out  1   FSM not IDLE
// err            out  1   sticky error; cleared by err_clr or reset
// err_clr        in   1   clears err (set has priority in same cycle)
// M_AXI_AW{ADDR,LEN,VALID} / M_AXI_AWREADY   out 32,8,1 / in 1   write address channel
// M_AXI_W{DATA,STRB,LAST,VALID} / M_AXI_WREADY   out 32,4,1,1 / in 1   write data channel
// M_AXI_B{RESP,VALID,ID} / M_AXI_BREADY   in 2,1,ID / out 1   write response channel
// M_AXI_AR{ADDR,LEN,VALID} / M_AXI_ARREADY   out 32,8,1 / in 1   read address channel
// M_AXI_R{DATA,RESP,LAST,VALID,ID} / M_AXI_RREADY   in 32,2,1,1,ID / out 1   read data channel
// Constant outputs:
//   *SIZE=3'b010; *BURST=2'b01; *LOCK=0; *CACHE=4'b0011; *PROT=0; *QOS=0; *REGION=0; *ID=0; *USER=0
// BEHAVIOUR
// - Reset:
//   - FSM to IDLE; beat counter 0; err 0.
//   - All VALID/READY outputs 0; cmd_ack 0; ADDR/LEN regs 0.
//   - Reset mid-burst abandons the transaction; no completion is attempted.
// - FSM states: IDLE, AW, W, B, AR, R.
// - IDLE, cmd_vld=1:
//   - cmd_ack=1 for that cycle; latch {cmd_addr[31:2],2'b00} and cmd_len.
//   - Next state AR if cmd_rnw=1, else AW.
//   - cmd_ack is registered.
// - 4KB check:
//   - If cmd_addr[11:2]+cmd_len > 1023, set err and stay in IDLE (no AXI activity).
//   - cmd_ack is still pulsed.
// - AW/AR state:
//   - AxVALID=1 is asserted the cycle after cmd_ack.
//   - ADDR/LEN are held stable until AxREADY; then go to W/R. AxVALID drops the next cycle.
// - W state (entered only after AW handshake):
//   - WVALID=wr_vld; WDATA/WSTRB=wr_data/wr_strb (combinational pass-through).
//   - wr_ack=WVALID&WREADY; the beat counter increments on each handshake.
//   - WLAST=1 when counter==latched LEN.
//   - On WLAST handshake, clear the counter and go to B.
//   - wr_vld low inserts bubbles; no timeout.
// - B state:
//   - BREADY=1; on BVALID go to IDLE.
//   - BRESP!=2'b00 sets err.
// - R state:
//   - RREADY=rd_rdy; rd_vld=RVALID; the counter increments on each RVALID&RREADY.
//   - RRESP!=0 on any beat sets err.
//   - Exit to IDLE on the RLAST handshake.
//   - If RLAST arrives with counter!=LEN, or counter==LEN without RLAST: set err; still exit only on RLAST.
// - busy=(state!=IDLE).
// - cmd_vld is ignored while busy; the next command can be acked in the cycle after returning to IDLE.
// - Latency: cmd_vld to AxVALID = 2 cycles minimum; the B handshake is followed by IDLE the next cycle.
// - err_clr with a simultaneous error source: err stays 1.
// TESTING
// - Write addr=0x1000 len=3, WREADY=AWREADY=1, wr_vld=1 -> 4 wr_acks, WLAST on beat 4 only, BREADY, busy 0.
// - Read addr=0x2004 len=0, RDATA=0xDEADBEEF RLAST=1 -> ARADDR=0x2004 ARLEN=0, rd_data=0xDEADBEEF rd_last=1.
// - Write addr=0x0FFC len=1 (crosses 4KB) -> cmd_ack, err=1, AWVALID never asserted.
// - Read len=7 with rd_rdy toggling and ARREADY delayed 5 cycles -> ARVALID stable 5 cycles, 8 beats, no loss or dup.
// - BRESP=2'b10 on a write -> err=1; err_clr -> err=0 next cycle.
// - Assert M_AXI_ARESET during beat 2 of a len=7 write -> all VALID/READY 0 immediately, busy 0, new command accepted.

Source files
------------

// File: rtl/axi_full_master_bridge.sv
// ---------------------------------------------------------------------------------------------
// axi_full_master_bridge
//
// Purpose:
//   AXI4-Full master that converts a simple command/stream interface into single-ID INCR
//   bursts of 32-bit words. Only one transaction is outstanding at a time, so reads and
//   writes are serialized. A burst that would cross a 4KB boundary is refused: the command
//   is still acknowledged, the sticky error flag is set, and no AXI traffic is issued.
//
// Ports:
//   M_AXI_ACLK / M_AXI_ARESET   clock (rising edge) / asynchronous active-high reset
//   cmd_*                       command request (read/write, byte address, AXI LEN), cmd_ack pulse
//   wr_*                        write beat stream in, wr_ack when a beat is consumed
//   rd_*                        read beat stream out, rd_rdy back-pressure from downstream
//   busy                        transaction in progress
//   err / err_clr               sticky error flag and its clear (set wins over clear)
//   M_AXI_AW* / W* / B*         AXI4 write address, data and response channels
//   M_AXI_AR* / R*              AXI4 read address and data channels
// ---------------------------------------------------------------------------------------------
module axi_full_master_bridge #(
   parameter int C_M_AXI_ID_WIDTH   = 1,
   parameter int C_M_AXI_USER_WIDTH = 1
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESET,
   // command interface
   input  logic                          cmd_vld,
   input  logic                          cmd_rnw,
   input  logic [31:0]                   cmd_addr,
   input  logic [7:0]                    cmd_len,
   output logic                          cmd_ack,
   // write beat stream
   input  logic [31:0]                   wr_data,
   input  logic [3:0]                    wr_strb,
   input  logic                          wr_vld,
   output logic                          wr_ack,
   // read beat stream
   output logic [31:0]                   rd_data,
   output logic                          rd_vld,
   output logic                          rd_last,
   input  logic                          rd_rdy,
   // status
   output logic                          busy,
   output logic                          err,
   input  logic                          err_clr,
   // write address channel
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_AWID,
   output logic [31:0]                   M_AXI_AWADDR,
   output logic [7:0]                    M_AXI_AWLEN,
   output logic [2:0]                    M_AXI_AWSIZE,
   output logic [1:0]                    M_AXI_AWBURST,
   output logic                          M_AXI_AWLOCK,
   output logic [3:0]                    M_AXI_AWCACHE,
   output logic [2:0]                    M_AXI_AWPROT,
   output logic [3:0]                    M_AXI_AWQOS,
   output logic [3:0]                    M_AXI_AWREGION,
   output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_AWUSER,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   // write data channel
   output logic [31:0]                   M_AXI_WDATA,
   output logic [3:0]                    M_AXI_WSTRB,
   output logic                          M_AXI_WLAST,
   output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_WUSER,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   // write response channel
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_BID,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   // read address channel
   output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
   output logic [31:0]                   M_AXI_ARADDR,
   output logic [7:0]                    M_AXI_ARLEN,
   output logic [2:0]                    M_AXI_ARSIZE,
   output logic [1:0]                    M_AXI_ARBURST,
   output logic                          M_AXI_ARLOCK,
   output logic [3:0]                    M_AXI_ARCACHE,
   output logic [2:0]                    M_AXI_ARPROT,
   output logic [3:0]                    M_AXI_ARQOS,
   output logic [3:0]                    M_AXI_ARREGION,
   output logic [C_M_AXI_USER_WIDTH-1:0] M_AXI_ARUSER,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   // read data channel
   input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
   input  logic [31:0]                   M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RLAST,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   typedef enum logic [2:0] {StIdle, StAw, StW, StB, StAr, StR} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  len_q, len_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        awvalid_q, awvalid_d;
   logic        arvalid_q, arvalid_d;
   logic        cmd_ack_q, cmd_ack_d;
   logic        err_q, err_d;
   logic        err_set;

   logic [10:0] end_word;
   logic        cross_4k;
   logic        w_hs;
   logic        r_hs;
   logic        cnt_at_len;

   // Word index of the final beat; bit 10 set means the burst runs past the 4KB page.
   assign end_word   = {1'b0, cmd_addr[11:2]} + {3'b000, cmd_len};
   assign cross_4k   = end_word[10];

   assign w_hs       = (state_q == StW) & wr_vld & M_AXI_WREADY;
   assign r_hs       = (state_q == StR) & M_AXI_RVALID & rd_rdy;
   assign cnt_at_len = (cnt_q == len_q);

   // ------------------------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      awvalid_d = 1'b0;
      arvalid_d = 1'b0;
      cmd_ack_d = 1'b0;
      err_set   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (cmd_vld) begin
               cmd_ack_d = 1'b1;
               addr_d    = {cmd_addr[31:2], 2'b00};
               len_d     = cmd_len;
               if (cross_4k) begin
                  err_set = 1'b1;
               end else if (cmd_rnw) begin
                  state_d = StAr;
               end else begin
                  state_d = StAw;
               end
            end
         end

         StAw: begin
            // VALID rises one cycle after entry and holds until the slave accepts.
            if (awvalid_q && M_AXI_AWREADY) begin
               state_d = StW;
            end else begin
               awvalid_d = 1'b1;
            end
         end

         StW: begin
            if (w_hs) begin
               if (cnt_at_len) begin
                  cnt_d   = 8'd0;
                  state_d = StB;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end

         StB: begin
            if (M_AXI_BVALID) begin
               state_d = StIdle;
               if (M_AXI_BRESP != 2'b00) begin
                  err_set = 1'b1;
               end
            end
         end

         StAr: begin
            if (arvalid_q && M_AXI_ARREADY) begin
               state_d = StR;
            end else begin
               arvalid_d = 1'b1;
            end
         end

         StR: begin
            if (r_hs) begin
               if (M_AXI_RRESP != 2'b00) begin
                  err_set = 1'b1;
               end
               // Slave burst length disagrees with the request: flag it, but only RLAST ends it.
               if (M_AXI_RLAST != cnt_at_len) begin
                  err_set = 1'b1;
               end
               if (M_AXI_RLAST) begin
                  cnt_d   = 8'd0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (err_set) begin
         err_d = 1'b1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         state_q   <= StIdle;
         addr_q    <= 32'd0;
         len_q     <= 8'd0;
         cnt_q     <= 8'd0;
         awvalid_q <= 1'b0;
         arvalid_q <= 1'b0;
         cmd_ack_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         awvalid_q <= awvalid_d;
         arvalid_q <= arvalid_d;
         cmd_ack_q <= cmd_ack_d;
         err_q     <= err_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   assign cmd_ack        = cmd_ack_q;
   assign busy           = (state_q != StIdle);
   assign err            = err_q;

   assign M_AXI_AWID     = '0;
   assign M_AXI_AWADDR   = addr_q;
   assign M_AXI_AWLEN    = len_q;
   assign M_AXI_AWSIZE   = 3'b010;
   assign M_AXI_AWBURST  = 2'b01;
   assign M_AXI_AWLOCK   = 1'b0;
   assign M_AXI_AWCACHE  = 4'b0011;
   assign M_AXI_AWPROT   = 3'b000;
   assign M_AXI_AWQOS    = 4'b0000;
   assign M_AXI_AWREGION = 4'b0000;
   assign M_AXI_AWUSER   = '0;
   assign M_AXI_AWVALID  = awvalid_q;

   // Write data is a straight pass-through; only VALID is qualified by state.
   assign M_AXI_WDATA    = wr_data;
   assign M_AXI_WSTRB    = wr_strb;
   assign M_AXI_WLAST    = (state_q == StW) & cnt_at_len;
   assign M_AXI_WUSER    = '0;
   assign M_AXI_WVALID   = (state_q == StW) & wr_vld;
   assign wr_ack         = w_hs;

   assign M_AXI_BREADY   = (state_q == StB);

   assign M_AXI_ARID     = '0;
   assign M_AXI_ARADDR   = addr_q;
   assign M_AXI_ARLEN    = len_q;
   assign M_AXI_ARSIZE   = 3'b010;
   assign M_AXI_ARBURST  = 2'b01;
   assign M_AXI_ARLOCK   = 1'b0;
   assign M_AXI_ARCACHE  = 4'b0011;
   assign M_AXI_ARPROT   = 3'b000;
   assign M_AXI_ARQOS    = 4'b0000;
   assign M_AXI_ARREGION = 4'b0000;
   assign M_AXI_ARUSER   = '0;
   assign M_AXI_ARVALID  = arvalid_q;

   assign M_AXI_RREADY   = (state_q == StR) & rd_rdy;
   assign rd_vld         = (state_q == StR) & M_AXI_RVALID;
   assign rd_data        = M_AXI_RDATA;
   assign rd_last        = M_AXI_RLAST;

   // Response IDs are always 0 with a single outstanding transaction; byte offset is dropped.
   logic unused_in;
   assign unused_in = ^{M_AXI_BID, M_AXI_RID, cmd_addr[1:0]};

endmodule

// File: tb/tb_axi_full_master_bridge.sv
// ---------------------------------------------------------------------------------------------
// tb_axi_full_master_bridge
//
// Table of commands run through the bridge against a small AXI slave model, with expected
// write/read beats queued when a command is issued and popped as the DUT produces them.
// Hand-written sequences cover reset mid-burst and err_clr racing an error.
// ---------------------------------------------------------------------------------------------
module tb_axi_full_master_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        M_AXI_ARESET = 1'b1;
   logic        cmd_vld = 1'b0, cmd_rnw = 1'b0;
   logic [31:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic        cmd_ack;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_strb = '0;
   logic        wr_vld = 1'b0, wr_ack;
   logic [31:0] rd_data;
   logic        rd_vld, rd_last;
   logic        rd_rdy = 1'b0;
   logic        busy, err;
   logic        err_clr = 1'b0;

   logic [0:0]  M_AXI_AWID, M_AXI_AWUSER, M_AXI_WUSER, M_AXI_ARID, M_AXI_ARUSER;
   logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA;
   logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
   logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE, M_AXI_AWPROT, M_AXI_ARPROT;
   logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST;
   logic        M_AXI_AWLOCK, M_AXI_ARLOCK;
   logic [3:0]  M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_AWQOS, M_AXI_ARQOS;
   logic [3:0]  M_AXI_AWREGION, M_AXI_ARREGION, M_AXI_WSTRB;
   logic        M_AXI_AWVALID, M_AXI_ARVALID, M_AXI_WVALID, M_AXI_WLAST;
   logic        M_AXI_BREADY, M_AXI_RREADY;
   logic        M_AXI_AWREADY = 1'b0, M_AXI_ARREADY = 1'b0, M_AXI_WREADY = 1'b0;
   logic [0:0]  M_AXI_BID = '0, M_AXI_RID = '0;
   logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
   logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0, M_AXI_RLAST = 1'b0;
   logic [31:0] M_AXI_RDATA = '0;

   axi_full_master_bridge #(
      .C_M_AXI_ID_WIDTH   (1),
      .C_M_AXI_USER_WIDTH (1)
   ) dut (
      .M_AXI_ACLK(clk), .M_AXI_ARESET(M_AXI_ARESET),
      .cmd_vld(cmd_vld), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .cmd_ack(cmd_ack), .wr_data(wr_data), .wr_strb(wr_strb), .wr_vld(wr_vld),
      .wr_ack(wr_ack), .rd_data(rd_data), .rd_vld(rd_vld), .rd_last(rd_last),
      .rd_rdy(rd_rdy), .busy(busy), .err(err), .err_clr(err_clr),
      .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
      .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
      .M_AXI_AWLOCK(M_AXI_AWLOCK), .M_AXI_AWCACHE(M_AXI_AWCACHE),
      .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
      .M_AXI_AWREGION(M_AXI_AWREGION), .M_AXI_AWUSER(M_AXI_AWUSER),
      .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
      .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
      .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY),
      .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
      .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE),
      .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
      .M_AXI_ARREGION(M_AXI_ARREGION), .M_AXI_ARUSER(M_AXI_ARUSER),
      .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   // ---------------------------------------------------------------------------------------
   // Checking
   // ---------------------------------------------------------------------------------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wdata_f(input int tag, input int i);
      return 32'hA500_0000 ^ 32'(tag << 16) ^ 32'(i);
   endfunction

   function automatic logic [3:0] wstrb_f(input int i);
      return 4'hF ^ 4'(i);
   endfunction

   function automatic logic [31:0] rdata_f(input int tag, input int i);
      return 32'hDEAD_BEEF ^ 32'(tag << 24) ^ 32'(i);
   endfunction

   // Scoreboards: {WDATA, WSTRB, WLAST} and {rd_data, rd_last}
   logic [36:0] wq[$];
   logic [32:0] rq[$];
   logic [36:0] we;
   logic [32:0] re;

   // ---------------------------------------------------------------------------------------
   // Slave model / monitor: drives inputs at negedge, samples handshakes 1ns later.
   // ---------------------------------------------------------------------------------------
   int   cfg_aw_delay = 0, cfg_ar_delay = 0, cfg_rlen_adj = 0;
   logic cfg_rd_toggle = 1'b0, cfg_wr_bubble = 1'b0;
   logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
   int   tag = 0;

   int   cyc = 0;
   int   aw_wait = 0, ar_wait = 0, w_idx = 0, r_idx = 0, r_len = 0;
   logic r_act = 1'b0, b_pend = 1'b0;
   int   aw_cycles = 0, ar_cycles = 0, aw_hs = 0, ar_hs = 0, w_hs_cnt = 0;
   int   ax_first_cyc = -1;
   logic [31:0] aw_addr_seen = '0, ar_addr_seen = '0, aw_addr_prev = '0, ar_addr_prev = '0;
   logic [7:0]  aw_len_seen = '0, ar_len_seen = '0, aw_len_prev = '0, ar_len_prev = '0;
   logic aw_pend_prev = 1'b0, ar_pend_prev = 1'b0;

   localparam logic [22:0] AxConst = {1'b0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'h0, 4'h0,
                                      1'b0};

   always @(negedge clk) begin
      M_AXI_AWREADY = (aw_wait >= cfg_aw_delay);
      M_AXI_ARREADY = (ar_wait >= cfg_ar_delay);
      M_AXI_WREADY  = 1'b1;
      wr_vld        = cfg_wr_bubble ? (cyc % 2 == 0) : 1'b1;
      wr_data       = wdata_f(tag, w_idx);
      wr_strb       = wstrb_f(w_idx);
      M_AXI_BVALID  = b_pend;
      M_AXI_BRESP   = b_pend ? cfg_bresp : 2'b00;
      M_AXI_RVALID  = r_act;
      M_AXI_RDATA   = rdata_f(tag, r_idx);
      M_AXI_RLAST   = r_act && (r_idx == r_len);
      M_AXI_RRESP   = r_act ? cfg_rresp : 2'b00;
      rd_rdy        = cfg_rd_toggle ? (cyc % 2 == 1) : 1'b1;
      #1;
      cyc++;
      if (M_AXI_ARESET) begin
         aw_wait = 0; ar_wait = 0; w_idx = 0; r_idx = 0;
         r_act = 1'b0; b_pend = 1'b0; aw_pend_prev = 1'b0; ar_pend_prev = 1'b0;
      end else begin
         // AW: address/len/valid must hold while stalled
         if (aw_pend_prev)
            chk("aw_stable", {M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWLEN},
                {1'b1, aw_addr_prev, aw_len_prev});
         if (M_AXI_AWVALID) begin
            aw_cycles++;
            if (ax_first_cyc < 0) ax_first_cyc = cyc;
            if (M_AXI_AWREADY) begin
               aw_hs++; aw_wait = 0;
               aw_addr_seen = M_AXI_AWADDR; aw_len_seen = M_AXI_AWLEN;
               chk("aw_const", {M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK,
                   M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWREGION, M_AXI_AWUSER},
                   AxConst);
            end else begin
               aw_wait++;
            end
         end
         aw_pend_prev = M_AXI_AWVALID && !M_AXI_AWREADY;
         aw_addr_prev = M_AXI_AWADDR; aw_len_prev = M_AXI_AWLEN;

         // W
         if (M_AXI_WVALID && M_AXI_WREADY) begin
            w_hs_cnt++;
            chk("wr_ack", wr_ack, 1'b1);
            chk("w_beat_expected", wq.size() != 0, 1'b1);
            if (wq.size() != 0) begin
               we = wq.pop_front();
               chk("w_beat", {M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST}, we);
            end
            if (M_AXI_WLAST) begin
               w_idx = 0; b_pend = 1'b1;
            end else begin
               w_idx++;
            end
         end

         // B
         if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1'b0;

         // AR
         if (ar_pend_prev)
            chk("ar_stable", {M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARLEN},
                {1'b1, ar_addr_prev, ar_len_prev});
         if (M_AXI_ARVALID) begin
            ar_cycles++;
            if (ax_first_cyc < 0) ax_first_cyc = cyc;
            if (M_AXI_ARREADY) begin
               ar_hs++; ar_wait = 0;
               ar_addr_seen = M_AXI_ARADDR; ar_len_seen = M_AXI_ARLEN;
               chk("ar_const", {M_AXI_ARID, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK,
                   M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARREGION, M_AXI_ARUSER},
                   AxConst);
               r_act = 1'b1; r_idx = 0; r_len = int'(M_AXI_ARLEN) + cfg_rlen_adj;
            end else begin
               ar_wait++;
            end
         end
         ar_pend_prev = M_AXI_ARVALID && !M_AXI_ARREADY;
         ar_addr_prev = M_AXI_ARADDR; ar_len_prev = M_AXI_ARLEN;

         // R
         if (M_AXI_RVALID && M_AXI_RREADY) begin
            chk("rd_vld", rd_vld, 1'b1);
            chk("r_beat_expected", rq.size() != 0, 1'b1);
            if (rq.size() != 0) begin
               re = rq.pop_front();
               chk("r_beat", {rd_data, rd_last}, re);
            end
            if (r_idx == r_len) begin
               r_act = 1'b0; r_idx = 0;
            end else begin
               r_idx++;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Command helpers
   // ---------------------------------------------------------------------------------------
   int issue_cyc = 0;

   task automatic run_cmd(input logic rnw, input logic [31:0] addr, input logic [7:0] len,
                          input logic clr);
      @(negedge clk);
      cmd_vld = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len; err_clr = clr;
      issue_cyc = cyc + 1;
      @(negedge clk);
      cmd_vld = 1'b0; err_clr = 1'b0;
      chk("cmd_ack_pulse", cmd_ack, 1'b1);
      @(negedge clk);
      chk("cmd_ack_drop", cmd_ack, 1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy || r_act || b_pend) && n < 600) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout_busy", busy, 1'b0);
   endtask

   task automatic reset_counters();
      aw_cycles = 0; ar_cycles = 0; aw_hs = 0; ar_hs = 0; w_hs_cnt = 0; ax_first_cyc = -1;
   endtask

   // ---------------------------------------------------------------------------------------
   // Vector table
   // ---------------------------------------------------------------------------------------
   typedef struct {
      logic        rnw;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [1:0]  bresp;
      logic [1:0]  rresp;
      int          aw_delay;
      int          ar_delay;
      logic        rd_toggle;
      logic        wr_bubble;
      int          rlen_adj;
      logic        exp_4k;
      logic        exp_err;
      logic [31:0] exp_addr;
   } vec_t;

   localparam int NumVec = 12;
   vec_t vecs[NumVec];
   vec_t t;
   int   nb;

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_2004, 8'd0,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b0,
                   32'h0000_2004};
      vecs[1]  = '{1'b0, 32'h0000_1000, 8'd3,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b0,
                   32'h0000_1000};
      vecs[2]  = '{1'b0, 32'h0000_0FFC, 8'd1,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b1, 1'b1,
                   32'h0000_0FFC};
      vecs[3]  = '{1'b1, 32'h0000_3000, 8'd7,  2'b00, 2'b00, 0, 5, 1'b1, 1'b0,  0, 1'b0, 1'b0,
                   32'h0000_3000};
      vecs[4]  = '{1'b0, 32'h0000_5000, 8'd1,  2'b10, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b1,
                   32'h0000_5000};
      vecs[5]  = '{1'b0, 32'h0000_1003, 8'd0,  2'b00, 2'b00, 0, 0, 1'b0, 1'b1,  0, 1'b0, 1'b0,
                   32'h0000_1000};
      vecs[6]  = '{1'b1, 32'h0000_4000, 8'd2,  2'b00, 2'b10, 0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b1,
                   32'h0000_4000};
      vecs[7]  = '{1'b1, 32'h0000_0FF0, 8'd3,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b0, 1'b0,
                   32'h0000_0FF0};
      vecs[8]  = '{1'b1, 32'h0000_0FF0, 8'd4,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0,  0, 1'b1, 1'b1,
                   32'h0000_0FF0};
      vecs[9]  = '{1'b0, 32'h0000_6008, 8'd15, 2'b00, 2'b00, 2, 0, 1'b0, 1'b1,  0, 1'b0, 1'b0,
                   32'h0000_6008};
      vecs[10] = '{1'b1, 32'h0000_7000, 8'd3,  2'b00, 2'b00, 0, 0, 1'b0, 1'b0, -1, 1'b0, 1'b1,
                   32'h0000_7000};
      vecs[11] = '{1'b1, 32'h0000_7100, 8'd3,  2'b00, 2'b00, 0, 0, 1'b1, 1'b0,  1, 1'b0, 1'b1,
                   32'h0000_7100};

      // Reset state
      repeat (3) @(negedge clk);
      #2;
      chk("reset_outputs", {cmd_ack, busy, err, wr_ack, rd_vld, M_AXI_AWVALID, M_AXI_WVALID,
          M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWADDR, M_AXI_AWLEN}, '0);
      @(negedge clk);
      M_AXI_ARESET = 1'b0;

      for (int v = 0; v < NumVec; v++) begin
         t = vecs[v];
         cfg_aw_delay = t.aw_delay; cfg_ar_delay = t.ar_delay; cfg_rlen_adj = t.rlen_adj;
         cfg_rd_toggle = t.rd_toggle; cfg_wr_bubble = t.wr_bubble;
         cfg_bresp = t.bresp; cfg_rresp = t.rresp;
         tag = v;
         reset_counters();
         if (!t.exp_4k) begin
            if (t.rnw) begin
               nb = int'(t.len) + 1 + t.rlen_adj;
               for (int i = 0; i < nb; i++) rq.push_back({rdata_f(v, i), i == nb - 1});
            end else begin
               for (int i = 0; i <= int'(t.len); i++)
                  wq.push_back({wdata_f(v, i), wstrb_f(i), i == int'(t.len)});
            end
         end
         run_cmd(t.rnw, t.addr, t.len, 1'b0);
         wait_idle();
         chk("err_after_cmd", err, t.exp_err);
         chk("wq_drained", wq.size(), 0);
         chk("rq_drained", rq.size(), 0);
         if (t.exp_4k) begin
            chk("no_axi_on_4k", aw_cycles + ar_cycles, 0);
         end else begin
            chk("ax_latency", ax_first_cyc - issue_cyc, 2);
            if (t.rnw) begin
               chk("ar_addr_len", {ar_addr_seen, ar_len_seen}, {t.exp_addr, t.len});
               chk("ar_valid_cycles", ar_cycles, t.ar_delay + 1);
               chk("ar_hs_once", {ar_hs, aw_cycles}, {32'd1, 32'd0});
            end else begin
               chk("aw_addr_len", {aw_addr_seen, aw_len_seen}, {t.exp_addr, t.len});
               chk("aw_valid_cycles", aw_cycles, t.aw_delay + 1);
               chk("aw_hs_once", {aw_hs, ar_cycles}, {32'd1, 32'd0});
               chk("w_beats", w_hs_cnt, int'(t.len) + 1);
            end
         end
         if (t.exp_err) begin
            @(negedge clk);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("err_clr", err, 1'b0);
         end
      end

      // err_clr coincident with a new error source: set wins
      cfg_aw_delay = 0; cfg_ar_delay = 0; cfg_rlen_adj = 0; cfg_rd_toggle = 1'b0;
      cfg_wr_bubble = 1'b0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;
      reset_counters();
      run_cmd(1'b0, 32'h0000_0FFC, 8'd1, 1'b0);
      chk("err_set_4k", err, 1'b1);
      run_cmd(1'b1, 32'h0000_0FF8, 8'd2, 1'b1);
      chk("err_set_beats_clr", err, 1'b1);
      chk("no_axi_err_seq", aw_cycles + ar_cycles, 0);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("err_clr_alone", err, 1'b0);

      // Reset during beat 2 of an 8-beat write
      tag = 20;
      reset_counters();
      for (int i = 0; i < 8; i++) wq.push_back({wdata_f(20, i), wstrb_f(i), i == 7});
      run_cmd(1'b0, 32'h0000_8000, 8'd7, 1'b0);
      for (int n = 0; n < 50 && w_hs_cnt < 2; n++) @(negedge clk);
      chk("reached_beat2", w_hs_cnt, 2);
      M_AXI_ARESET = 1'b1;
      #2;
      chk("rst_valids_low", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
          M_AXI_RREADY, wr_ack, rd_vld, cmd_ack}, 8'h00);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      M_AXI_ARESET = 1'b0;
      wq.delete();
      tag = 21;
      reset_counters();
      for (int i = 0; i < 2; i++) rq.push_back({rdata_f(21, i), i == 1});
      run_cmd(1'b1, 32'h0000_9000, 8'd1, 1'b0);
      wait_idle();
      chk("post_rst_read", {ar_hs, ar_addr_seen, aw_cycles}, {32'd1, 32'h0000_9000, 32'd0});
      chk("post_rst_rq", rq.size(), 0);
      chk("post_rst_err", err, 1'b0);

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

endmodule
